// File: rtl/dc_tag_bank_arbiter_if.sv
// Request/ack channel between a tag requester and a tag bank.
// The same bundle is used on the requester side and on the bank side.
interface dc_tag_bank_arbiter_if #(
    parameter int Width    = 24,
    parameter int REQ_BITS = 7
);
    logic                req_valid;
    logic                req_retry;
    logic [Width-1:0]    req_data;
    logic [REQ_BITS-1:0] req_type;
    logic                write;
    logic                ack_valid;
    logic                ack_retry;
    logic                hit;
    logic                miss;
    logic [2:0]          way;

    modport master (
        output req_valid, req_data, req_type, write, ack_retry,
        input  req_retry, ack_valid, hit, miss, way
    );

    modport slave (
        input  req_valid, req_data, req_type, write, ack_retry,
        output req_retry, ack_valid, hit, miss, way
    );
endinterface

// File: rtl/dc_tag_bank_arbiter.sv
// Two-requester to two-bank (even/odd) tag lookup arbiter.
// Define DC_TAG_ARB_PERF_EN to add per-bank conflict counters.
module dc_tag_bank_arbiter #(
    parameter int Width    = 24,
    parameter int REQ_BITS = 7,
    parameter int SEL_BIT  = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    dc_tag_bank_arbiter_if.slave   p0,
    dc_tag_bank_arbiter_if.slave   p1,
    dc_tag_bank_arbiter_if.master  even,
    dc_tag_bank_arbiter_if.master  odd
`ifdef DC_TAG_ARB_PERF_EN
    ,
    output logic [15:0]            even_conflict_cnt,
    output logic [15:0]            odd_conflict_cnt
`endif
);

    typedef enum logic {IDLE, BUSY} state_e;

    // Index 0 is the even bank, index 1 the odd bank.
    state_e     state_q [2];
    state_e     state_d [2];
    logic [1:0] owner_q, owner_d;
    logic [1:0] ptr_q, ptr_d;

    logic [1:0] want0, want1, rdy, gnt0, gnt1;
    logic [1:0] busy, aval, dlv, own_rty, done;
    logic       odd_blk;
    logic       s0e, s0o, s1e, s1o;

    assign want0 = {p0.req_valid &  p0.req_data[SEL_BIT],
                    p0.req_valid & ~p0.req_data[SEL_BIT]};
    assign want1 = {p1.req_valid &  p1.req_data[SEL_BIT],
                    p1.req_valid & ~p1.req_data[SEL_BIT]};

    assign busy = {state_q[1] == BUSY, state_q[0] == BUSY};
    assign rdy  = {2{reset}} & ~busy
                & ~{odd.req_retry, even.req_retry};
    assign gnt0 = rdy & want0 & (~want1 | ~ptr_q);
    assign gnt1 = rdy & want1 & (~want0 |  ptr_q);

    assign p0.req_retry = p0.req_valid & ~|gnt0;
    assign p1.req_retry = p1.req_valid & ~|gnt1;

    assign even.req_valid = gnt0[0] | gnt1[0];
    assign even.req_data  = ({Width{gnt0[0]}} & p0.req_data)
                          | ({Width{gnt1[0]}} & p1.req_data);
    assign even.req_type  = ({REQ_BITS{gnt0[0]}} & p0.req_type)
                          | ({REQ_BITS{gnt1[0]}} & p1.req_type);
    assign even.write     = (gnt0[0] & p0.write)
                          | (gnt1[0] & p1.write);

    assign odd.req_valid  = gnt0[1] | gnt1[1];
    assign odd.req_data   = ({Width{gnt0[1]}} & p0.req_data)
                          | ({Width{gnt1[1]}} & p1.req_data);
    assign odd.req_type   = ({REQ_BITS{gnt0[1]}} & p0.req_type)
                          | ({REQ_BITS{gnt1[1]}} & p1.req_type);
    assign odd.write      = (gnt0[1] & p0.write)
                          | (gnt1[1] & p1.write);

    // Same owner completing on both banks: even goes first, odd waits.
    assign aval    = busy & {odd.ack_valid, even.ack_valid};
    assign odd_blk = &aval & (owner_q[0] == owner_q[1]);
    assign dlv     = aval & {~odd_blk, 1'b1};
    assign own_rty = {owner_q[1] ? p1.ack_retry : p0.ack_retry,
                      owner_q[0] ? p1.ack_retry : p0.ack_retry};
    assign done    = dlv & ~own_rty;

    assign even.ack_retry = busy[0] & own_rty[0];
    assign odd.ack_retry  = busy[1] & (own_rty[1] | odd_blk);

    assign s0e = dlv[0] & ~owner_q[0];
    assign s0o = dlv[1] & ~owner_q[1];
    assign s1e = dlv[0] &  owner_q[0];
    assign s1o = dlv[1] &  owner_q[1];

    assign p0.ack_valid = s0e | s0o;
    assign p0.hit  = (s0e & even.hit)  | (s0o & odd.hit);
    assign p0.miss = (s0e & even.miss) | (s0o & odd.miss);
    assign p0.way  = ({3{s0e}} & even.way) | ({3{s0o}} & odd.way);

    assign p1.ack_valid = s1e | s1o;
    assign p1.hit  = (s1e & even.hit)  | (s1o & odd.hit);
    assign p1.miss = (s1e & even.miss) | (s1o & odd.miss);
    assign p1.way  = ({3{s1e}} & even.way) | ({3{s1o}} & odd.way);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q ^ (rdy & want0 & want1);
        for (int b = 0; b < 2; b++) begin
            unique case (state_q[b])
                IDLE: begin
                    if (gnt0[b] | gnt1[b]) begin
                        state_d[b] = BUSY;
                        owner_d[b] = gnt1[b];
                    end
                end
                BUSY: begin
                    if (done[b]) state_d[b] = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= '{IDLE, IDLE};
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef DC_TAG_ARB_PERF_EN
    logic [1:0]  both;
    logic [15:0] ecnt_q, ecnt_d;
    logic [15:0] ocnt_q, ocnt_d;

    assign both = want0 & want1;

    always_comb begin
        ecnt_d = ecnt_q;
        ocnt_d = ocnt_q;
        if (both[0] && ecnt_q != 16'hFFFF) ecnt_d = ecnt_q + 16'd1;
        if (both[1] && ocnt_q != 16'hFFFF) ocnt_d = ocnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ecnt_q <= '0;
            ocnt_q <= '0;
        end else begin
            ecnt_q <= ecnt_d;
            ocnt_q <= ocnt_d;
        end
    end

    assign even_conflict_cnt = ecnt_q;
    assign odd_conflict_cnt  = ocnt_q;
`endif

endmodule

// File: tb/tb_dc_tag_bank_arbiter.sv
// Directed scoreboard bench for dc_tag_bank_arbiter.
// Each step queues the full expected output snapshot and checks it mid-cycle.
module tb_dc_tag_bank_arbiter;

    localparam logic [23:0] A_E0 = 24'h000111;
    localparam logic [23:0] A_E1 = 24'h000222;
    localparam logic [23:0] A_O1 = 24'h000633;

    typedef struct packed {
        logic        p0r, p1r;
        logic        ev, ov, ewr, owr;
        logic [23:0] ed, od;
        logic        p0a, p1a, p0h, p1h, p0m, p1m;
        logic [2:0]  p0w, p1w;
        logic        er, orr;
    } snap_t;

    logic  clk;
    logic  reset;
    int    n_vec;
    int    n_err;
    snap_t e;
    snap_t sb [$];

    dc_tag_bank_arbiter_if #(.Width(24), .REQ_BITS(7)) p0_if ();
    dc_tag_bank_arbiter_if #(.Width(24), .REQ_BITS(7)) p1_if ();
    dc_tag_bank_arbiter_if #(.Width(24), .REQ_BITS(7)) ev_if ();
    dc_tag_bank_arbiter_if #(.Width(24), .REQ_BITS(7)) od_if ();

`ifdef DC_TAG_ARB_PERF_EN
    logic [15:0] ecnt, ocnt;
`endif

    dc_tag_bank_arbiter #(
        .Width(24),
        .REQ_BITS(7),
        .SEL_BIT(10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .p0    (p0_if),
        .p1    (p1_if),
        .even  (ev_if),
        .odd   (od_if)
`ifdef DC_TAG_ARB_PERF_EN
        ,
        .even_conflict_cnt (ecnt),
        .odd_conflict_cnt  (ocnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic snap_t grab();
        snap_t s;
        s.p0r = p0_if.req_retry;
        s.p1r = p1_if.req_retry;
        s.ev  = ev_if.req_valid;
        s.ov  = od_if.req_valid;
        s.ewr = ev_if.write;
        s.owr = od_if.write;
        s.ed  = ev_if.req_data;
        s.od  = od_if.req_data;
        s.p0a = p0_if.ack_valid;
        s.p1a = p1_if.ack_valid;
        s.p0h = p0_if.hit;
        s.p1h = p1_if.hit;
        s.p0m = p0_if.miss;
        s.p1m = p1_if.miss;
        s.p0w = p0_if.way;
        s.p1w = p1_if.way;
        s.er  = ev_if.ack_retry;
        s.orr = od_if.ack_retry;
        return s;
    endfunction

    task automatic clr();
        p0_if.req_valid = 0; p0_if.req_data = '0;
        p0_if.req_type = '0; p0_if.write = 0;
        p0_if.ack_retry = 0;
        p1_if.req_valid = 0; p1_if.req_data = '0;
        p1_if.req_type = '0; p1_if.write = 0;
        p1_if.ack_retry = 0;
        ev_if.req_retry = 0; ev_if.ack_valid = 0;
        ev_if.hit = 0; ev_if.miss = 0; ev_if.way = '0;
        od_if.req_retry = 0; od_if.ack_valid = 0;
        od_if.hit = 0; od_if.miss = 0; od_if.way = '0;
    endtask

    task automatic req(input bit n, input logic [23:0] d,
                       input logic w);
        if (n == 1'b0) begin
            p0_if.req_valid = 1; p0_if.req_data = d;
            p0_if.write = w; p0_if.req_type = 7'h11;
        end else begin
            p1_if.req_valid = 1; p1_if.req_data = d;
            p1_if.write = w; p1_if.req_type = 7'h22;
        end
    endtask

    task automatic back(input bit b, input logic h, input logic m,
                        input logic [2:0] w);
        if (b == 1'b0) begin
            ev_if.ack_valid = 1; ev_if.hit = h;
            ev_if.miss = m; ev_if.way = w;
        end else begin
            od_if.ack_valid = 1; od_if.hit = h;
            od_if.miss = m; od_if.way = w;
        end
    endtask

    task automatic step(input string tag, input snap_t x);
        snap_t o, w;
        sb.push_back(x);
        #2;
        o = grab();
        w = sb.pop_front();
        n_vec++;
        assert (o === w) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, o, w);
        end
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        clr();
        @(negedge clk);

        req(0, A_E0, 0); req(1, A_O1, 0);
        back(0, 1, 0, 3'd5); back(1, 0, 1, 3'd2);
        e = '0; e.p0r = 1; e.p1r = 1;
        step("in_reset", e);

        reset = 1'b1;
        clr(); req(0, A_E0, 1); req(1, A_O1, 0);
        e = '0; e.ev = 1; e.ed = A_E0; e.ewr = 1;
        e.ov = 1; e.od = A_O1;
        step("split_grant", e);

        clr(); back(0, 1, 0, 3'd5); back(1, 0, 1, 3'd2);
        e = '0; e.p0a = 1; e.p0h = 1; e.p0w = 3'd5;
        e.p1a = 1; e.p1m = 1; e.p1w = 3'd2;
        step("split_ack", e);

        for (int i = 0; i < 4; i++) begin
            clr(); req(0, A_E0, 0); req(1, A_E1, 0);
            e = '0; e.ev = 1;
            if (i % 2 == 0) begin
                e.ed = A_E0; e.p1r = 1;
            end else begin
                e.ed = A_E1; e.p0r = 1;
            end
            step("rr_grant", e);
            clr(); req(0, A_E0, 0); req(1, A_E1, 0);
            back(0, 0, 0, 3'(i + 1));
            e = '0; e.p0r = 1; e.p1r = 1;
            if (i % 2 == 0) begin
                e.p0a = 1; e.p0w = 3'(i + 1);
            end else begin
                e.p1a = 1; e.p1w = 3'(i + 1);
            end
            step("rr_ack", e);
        end

`ifdef DC_TAG_ARB_PERF_EN
        n_vec++;
        assert (ecnt === 16'd8 && ocnt === 16'd0) else begin
            n_err++;
            $error("FAIL perf_cnt: observed %0d/%0d expected 8/0",
                   ecnt, ocnt);
        end
`endif

        clr(); req(0, A_E0, 0);
        e = '0; e.ev = 1; e.ed = A_E0;
        step("ar_grant", e);
        for (int j = 0; j < 2; j++) begin
            clr(); back(0, 0, 0, 3'd6); p0_if.ack_retry = 1;
            e = '0; e.p0a = 1; e.p0w = 3'd6; e.er = 1;
            step("ar_hold", e);
        end
        clr(); back(0, 0, 0, 3'd6); req(1, A_E1, 0);
        e = '0; e.p0a = 1; e.p0w = 3'd6; e.p1r = 1;
        step("ar_done", e);
        clr(); req(1, A_E1, 0);
        e = '0; e.ev = 1; e.ed = A_E1;
        step("ar_regrant", e);
        clr(); back(0, 1, 0, 3'd7);
        e = '0; e.p1a = 1; e.p1h = 1; e.p1w = 3'd7;
        step("ar_p1ack", e);

        for (int k = 0; k < 2; k++) begin
            clr(); od_if.req_retry = 1; req(1, A_O1, 0);
            e = '0; e.p1r = 1;
            step("bank_retry", e);
        end
        clr(); req(1, A_O1, 0);
        e = '0; e.ov = 1; e.od = A_O1;
        step("bank_go", e);
        clr(); req(1, A_E1, 0);
        e = '0; e.ev = 1; e.ed = A_E1;
        step("p1_even", e);
        clr(); back(0, 1, 0, 3'd1); back(1, 0, 1, 3'd2);
        e = '0; e.p1a = 1; e.p1h = 1; e.p1w = 3'd1; e.orr = 1;
        step("dual_ack", e);
        clr(); back(1, 0, 1, 3'd2);
        e = '0; e.p1a = 1; e.p1m = 1; e.p1w = 3'd2;
        step("odd_ack", e);
        clr(); back(0, 1, 1, 3'd3); back(1, 1, 1, 3'd3);
        p0_if.ack_retry = 1; p1_if.ack_retry = 1;
        e = '0;
        step("idle_drop", e);

        clr(); req(0, A_E0, 0); req(1, A_E1, 0);
        e = '0; e.ev = 1; e.ed = A_E0; e.p1r = 1;
        step("pre_contend", e);
        clr(); req(1, A_O1, 0);
        e = '0; e.ov = 1; e.od = A_O1;
        step("pre_odd", e);
        reset = 1'b0;
        clr(); back(0, 1, 0, 3'd4); back(1, 1, 0, 3'd4);
        e = '0;
        step("rst_busy", e);
        reset = 1'b1;
        clr(); back(0, 1, 0, 3'd4); back(1, 1, 0, 3'd4);
        e = '0;
        step("post_drop", e);
        clr(); req(0, A_E0, 0); req(1, A_E1, 0);
        e = '0; e.ev = 1; e.ed = A_E0; e.p1r = 1;
        step("ptr_reset", e);

`ifdef DC_TAG_ARB_PERF_EN
        n_vec++;
        assert (ecnt === 16'd1 && ocnt === 16'd0) else begin
            n_err++;
            $error("FAIL perf_rst: observed %0d/%0d expected 1/0",
                   ecnt, ocnt);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dc_tag_bank_arbiter.md
DC_TAG_BANK_ARBITER -- requirements
Module: dc_tag_bank_arbiter

Interface
REQ-001 Parameter Width, default 24, request and tag data width.
REQ-002 Parameter REQ_BITS, default 7, request type width.
REQ-003 Parameter SEL_BIT, default 10, bit of req_data selecting bank (0 = even, 1 = odd).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 pN_req_valid / pN_req_retry  in / out  1 / 1  requester N (N=0 core, N=1 snoop/fill) request handshake.
REQ-007 pN_req_data  in  Width  tag/index payload of requester N.
REQ-008 pN_req_type / pN_write  in  REQ_BITS / 1  request type and write enable of requester N.
REQ-009 pN_ack_valid / pN_ack_retry  out / in  1 / 1  response handshake to requester N.
REQ-010 pN_hit, pN_miss, pN_way  out  1, 1, 3  lookup result routed to requester N.
REQ-011 B_req_valid / B_req_retry  out / in  1 / 1  bank B (B=even, odd) request handshake.
REQ-012 B_req_data, B_req_type, B_write  out  Width, REQ_BITS, 1  muxed payload to bank B.
REQ-013 B_ack_valid / B_ack_retry  in / out  1 / 1  bank B response handshake.
REQ-014 B_hit, B_miss, B_way  in  1, 1, 3  bank B lookup result.

Function
REQ-015 Target bank of requester N SHALL be pN_req_data[SEL_BIT].
REQ-016 Each bank SHALL hold a 2-state FSM: IDLE, BUSY(owner).
REQ-017 Bank is grantable in cycle t only if IDLE and B_req_retry = 0.
REQ-018 Grant SHALL be combinational: B_req_valid and payload driven in the same cycle as the winning pN_req_valid.
REQ-019 Requests to different grantable banks SHALL both be granted in the same cycle.
REQ-020 Same-bank contention SHALL be resolved by a per-bank 1-bit round-robin pointer (reset 0 = p0 priority); pointer toggles to the loser after every contended grant only.
REQ-021 pN_req_retry = pN_req_valid AND NOT granted; requester holds payload while retried.
REQ-022 On grant: IDLE -> BUSY, owner = N, registered at clock edge.
REQ-023 While BUSY, B_ack_valid, B_hit, B_miss, B_way SHALL route combinationally to owner; B_ack_retry = owner's pN_ack_retry.
REQ-024 BUSY -> IDLE when B_ack_valid = 1 and owner pN_ack_retry = 0; bank not regrantable in that same cycle (earliest next grant t+1).
REQ-025 B_ack_valid in IDLE SHALL be dropped (no pN_ack_valid) and B_ack_retry = 0.
REQ-026 Both banks completing in one cycle to the same owner: even bank delivered, odd bank held via odd_ack_retry = 1.
REQ-027 Non-owner pN_ack_valid and pN_hit/miss/way SHALL be 0.

Reset
REQ-028 reset low SHALL immediately force both FSMs IDLE, pointers 0, counters 0; in-flight requests are dropped.
REQ-029 During reset all outputs SHALL be 0 except pN_req_retry = pN_req_valid.

Configuration
REQ-030 Macro DC_TAG_ARB_PERF_EN defined: adds outputs even_conflict_cnt and odd_conflict_cnt (16 bits each), incremented on every cycle both requesters target that bank, saturating at 0xFFFF.
REQ-031 Macro undefined: counters and ports absent; all other behaviour identical.

Verification
REQ-032 p0 data[10]=0, p1 data[10]=1, same cycle -> both granted, even owner p0, odd owner p1, no retry.
REQ-033 Both target even for 4 consecutive grants -> grant order p0, p1, p0, p1; loser sees retry each cycle.
REQ-034 even BUSY(p0), even_ack_valid with p0_ack_retry=1 for 2 cycles then 0 -> p0_ack_valid 3 cycles, even_ack_retry mirrors, IDLE after the third cycle, new grant no earlier than next cycle.
REQ-035 odd_req_retry=1 with p1 targeting odd -> p1_req_retry=1, FSM stays IDLE; retry drops -> grant same cycle.
REQ-036 reset asserted while both banks BUSY, then bank acks arrive -> acks dropped, all pN_ack_valid=0, pointers 0.
REQ-037 DC_TAG_ARB_PERF_EN defined, 5 contended even cycles -> even_conflict_cnt=5, odd_conflict_cnt=0; preload saturation -> stays 0xFFFF.
